display_scan_ctrl: RTL

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: walks NDIGITS digits with a blanking
// gap between each, double-buffering digit codes so a frame never mixes data.
module display_scan_ctrl #(
   parameter int NDIGITS = 4,
   parameter int DWELL   = 50000,
   parameter int BLANK   = 500
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [$clog2(NDIGITS)-1:0] wr_digit,
   input  logic [4:0]                 wr_code,
   input  logic                       lz_en,
   output logic [4:0]                 num,
   output logic [NDIGITS-1:0]         dig_en_n,
   output logic                       frame_tick
);
   localparam int IW   = $clog2(NDIGITS);
   localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CW   = $clog2(MAXC);
   localparam logic [CW-1:0] DWELL_LD   = CW'(DWELL - 1);
   localparam logic [CW-1:0] BLANK_LD   = CW'(BLANK - 1);
   localparam logic [IW-1:0] LAST_IDX   = IW'(NDIGITS - 1);
   localparam logic [4:0]    CODE_BLANK = 5'd31;

   typedef enum logic {SHOW, GAP} state_e;

   state_e                   state_q, state_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [NDIGITS-1:0][4:0]  shadow_q, shadow_d;
   logic [NDIGITS-1:0][4:0]  active_q, active_d;
   logic [4:0]               num_q, num_d;
   logic [NDIGITS-1:0]       dig_en_n_q, dig_en_n_d;
   logic                     frame_tick_q, frame_tick_d;
   logic                     commit;
   logic                     higher_ok;
   logic [NDIGITS-1:0]       lz_zero;

   assign commit   = (state_q == GAP) && (idx_q == LAST_IDX) && (cnt_q == '0);
   assign wr_ready = !commit;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      shadow_d     = shadow_q;
      active_d     = commit ? shadow_q : active_q;
      num_d        = CODE_BLANK;
      dig_en_n_d   = '1;
      frame_tick_d = commit;
      higher_ok    = 1'b1;
      lz_zero      = '0;

      if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end else if (state_q == SHOW) begin
         state_d = GAP;
         cnt_d   = BLANK_LD;
      end else begin
         state_d = SHOW;
         cnt_d   = DWELL_LD;
         idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
      end

      // Indices that don't decode to a digit simply match no entry.
      if (wr_valid && wr_ready) begin
         for (int i = 0; i < NDIGITS; i++) begin
            if (wr_digit == IW'(i)) shadow_d[i] = wr_code;
         end
      end

      // Scan from the top digit down; a zero blanks while everything above is 0/blank.
      for (int i = NDIGITS - 1; i >= 1; i--) begin
         lz_zero[i] = higher_ok && (active_d[i] == 5'd0);
         higher_ok  = higher_ok && ((active_d[i] == 5'd0) || (active_d[i] >= 5'd17));
      end

      // Display outputs are decoded from the next state so they line up with state_q.
      if (state_d == SHOW) begin
         dig_en_n_d[idx_d] = 1'b0;
         num_d = (lz_en && lz_zero[idx_d]) ? CODE_BLANK : active_d[idx_d];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= GAP;
         idx_q        <= LAST_IDX;
         cnt_q        <= '0;
         shadow_q     <= '1;
         active_q     <= '1;
         num_q        <= CODE_BLANK;
         dig_en_n_q   <= '1;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         shadow_q     <= shadow_d;
         active_q     <= active_d;
         num_q        <= num_d;
         dig_en_n_q   <= dig_en_n_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign num        = num_q;
   assign dig_en_n   = dig_en_n_q;
   assign frame_tick = frame_tick_q;

endmodule
